rvh_l1d_bank_axi_ostd_ctrl: RTL

- Per-bank outstanding-transaction controller between the L1D banks and the L1D-to-L2 AXI round-robin arbiter.
- Gates each bank's AR, AW and W valid/ready so that no bank exceeds its read or write credit limit.
- Returns credits on R-last and B handshakes, steered by the bank index carried in RID/BID.
- Provides a drain handshake that quiesces all new traffic and waits for every outstanding transaction before fence/flush.

---
 rtl/rvh_l1d_pkg.sv | 14 +
 rtl/rvh_l1d_ostd_credit_cnt.sv | 31 +++
 rtl/rvh_l1d_bank_axi_ostd_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: AXI outstanding-control FSM states and default limits.
package rvh_l1d_pkg;

    localparam int L1D_BANK_ID_NUM = 4;
    localparam int L1D_AR_OSTD_MAX = 4;
    localparam int L1D_AW_OSTD_MAX = 2;

    typedef enum logic [1:0] {
        OSTD_RUN     = 2'd0,
        OSTD_DRAIN   = 2'd1,
        OSTD_DRAINED = 2'd2
    } l1d_axi_ostd_fsm_e;

endpackage

// File: rtl/rvh_l1d_ostd_credit_cnt.sv
// Saturating outstanding-credit counter; flags a return with no credit held.
module rvh_l1d_ostd_credit_cnt #(
    parameter int MAX   = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             allow,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;

    assign cnt       = cnt_q;
    assign allow     = cnt_q < CNT_W'(MAX);
    assign underflow = dec & ~inc & (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc & ~dec) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec & ~inc & (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rvh_l1d_bank_axi_ostd_ctrl.sv
// Per-bank AR/AW/W credit gating toward the L2 AXI arbiter, with a
// drain handshake that quiesces traffic before fence/flush.
module rvh_l1d_bank_axi_ostd_ctrl
    import rvh_l1d_pkg::*;
#(
    parameter int INPUT_PORT_NUM = L1D_BANK_ID_NUM,
    parameter int INPUT_PORT_NUM_INDEX_WIDTH =
        (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1,
    parameter int AR_OSTD_MAX = L1D_AR_OSTD_MAX,
    parameter int AW_OSTD_MAX = L1D_AW_OSTD_MAX,
    parameter int OSTD_CNT_W = $clog2(
        ((AR_OSTD_MAX > AW_OSTD_MAX) ? AR_OSTD_MAX : AW_OSTD_MAX) + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INPUT_PORT_NUM-1:0]             bank_arvalid_i,
    output logic [INPUT_PORT_NUM-1:0]             bank_arready_o,
    output logic [INPUT_PORT_NUM-1:0]             arb_arvalid_o,
    input  logic [INPUT_PORT_NUM-1:0]             arb_arready_i,
    input  logic [INPUT_PORT_NUM-1:0]             bank_awvalid_i,
    output logic [INPUT_PORT_NUM-1:0]             bank_awready_o,
    output logic [INPUT_PORT_NUM-1:0]             arb_awvalid_o,
    input  logic [INPUT_PORT_NUM-1:0]             arb_awready_i,
    input  logic [INPUT_PORT_NUM-1:0]             bank_wvalid_i,
    output logic [INPUT_PORT_NUM-1:0]             bank_wready_o,
    output logic [INPUT_PORT_NUM-1:0]             arb_wvalid_o,
    input  logic [INPUT_PORT_NUM-1:0]             arb_wready_i,
    input  logic [INPUT_PORT_NUM-1:0]             bank_wlast_i,
    input  logic                                  l2_r_hsk_i,
    input  logic                                  l2_rlast_i,
    input  logic [INPUT_PORT_NUM_INDEX_WIDTH-1:0] l2_r_bank_idx_i,
    input  logic                                  l2_b_hsk_i,
    input  logic [INPUT_PORT_NUM_INDEX_WIDTH-1:0] l2_b_bank_idx_i,
    input  logic                                  drain_req_i,
    output logic                                  drain_ack_o,
    output logic                                  ostd_busy_o,
    output logic                                  ostd_err_o
);

    localparam int N = INPUT_PORT_NUM;

    l1d_axi_ostd_fsm_e fsm_q, fsm_d;

    logic                           run;
    logic [N-1:0]                   ar_room, aw_room;
    logic [N-1:0]                   ar_allow, aw_allow, w_allow;
    logic [N-1:0]                   ar_hsk, aw_hsk, w_hsk;
    logic [N-1:0]                   ar_dec, aw_dec;
    logic [N-1:0]                   ar_uf, aw_uf;
    logic [N-1:0]                   w_in_burst;
    logic [N-1:0][OSTD_CNT_W-1:0]   ar_cnt, aw_cnt;
    logic                           r_ret, r_ok, b_ok, idx_err;
    logic                           err_q;

    assign run      = (fsm_q == OSTD_RUN);
    assign ar_allow = ar_room & {N{run}};
    assign aw_allow = aw_room & {N{run}};
    // An open W burst must finish even while draining.
    assign w_allow  = w_in_burst | aw_allow;

    assign arb_arvalid_o  = bank_arvalid_i & ar_allow;
    assign bank_arready_o = arb_arready_i  & ar_allow;
    assign arb_awvalid_o  = bank_awvalid_i & aw_allow;
    assign bank_awready_o = arb_awready_i  & aw_allow;
    assign arb_wvalid_o   = bank_wvalid_i  & w_allow;
    assign bank_wready_o  = arb_wready_i   & w_allow;

    assign ar_hsk = arb_arvalid_o & arb_arready_i;
    assign aw_hsk = arb_awvalid_o & arb_awready_i;
    assign w_hsk  = arb_wvalid_o  & arb_wready_i;

    assign r_ret   = l2_r_hsk_i & l2_rlast_i;
    assign r_ok    = 32'(l2_r_bank_idx_i) < N;
    assign b_ok    = 32'(l2_b_bank_idx_i) < N;
    assign idx_err = (r_ret & ~r_ok) | (l2_b_hsk_i & ~b_ok);

    always_comb begin
        ar_dec = '0;
        aw_dec = '0;
        if (r_ret & r_ok) begin
            ar_dec[l2_r_bank_idx_i] = 1'b1;
        end
        if (l2_b_hsk_i & b_ok) begin
            aw_dec[l2_b_bank_idx_i] = 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_bank
        rvh_l1d_ostd_credit_cnt #(
            .MAX   (AR_OSTD_MAX),
            .CNT_W (OSTD_CNT_W)
        ) u_ar_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (ar_hsk[i]),
            .dec       (ar_dec[i]),
            .cnt       (ar_cnt[i]),
            .allow     (ar_room[i]),
            .underflow (ar_uf[i])
        );

        rvh_l1d_ostd_credit_cnt #(
            .MAX   (AW_OSTD_MAX),
            .CNT_W (OSTD_CNT_W)
        ) u_aw_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (aw_hsk[i]),
            .dec       (aw_dec[i]),
            .cnt       (aw_cnt[i]),
            .allow     (aw_room[i]),
            .underflow (aw_uf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_in_burst <= '0;
            err_q      <= 1'b0;
            fsm_q      <= OSTD_RUN;
        end else begin
            w_in_burst <= (w_in_burst & ~w_hsk) | (w_hsk & ~bank_wlast_i);
            err_q      <= err_q | (|ar_uf) | (|aw_uf) | idx_err;
            fsm_q      <= fsm_d;
        end
    end

    assign ostd_busy_o = (|ar_cnt) | (|aw_cnt) | (|w_in_burst);
    assign ostd_err_o  = err_q;
    assign drain_ack_o = (fsm_q == OSTD_DRAINED);

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            OSTD_RUN: begin
                if (drain_req_i) fsm_d = OSTD_DRAIN;
            end
            OSTD_DRAIN: begin
                if (!drain_req_i)     fsm_d = OSTD_RUN;
                else if (!ostd_busy_o) fsm_d = OSTD_DRAINED;
            end
            OSTD_DRAINED: begin
                if (!drain_req_i) fsm_d = OSTD_RUN;
            end
            default: fsm_d = OSTD_RUN;
        endcase
    end

endmodule
